// File: rtl/eth_rx_framer.sv
// eth_rx_framer: GMII receive framer that strips preamble/SFD, writes payload to a FIFO and reports per-frame status.
module eth_rx_framer #(
  parameter int PREAMBLE_MIN = 7,
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518,
  parameter int LEN_WIDTH = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_dv,
  input  logic                 rx_er,
  input  logic [7:0]           rxd,
  input  logic                 fifo_full,
  output logic                 fifo_wr_en,
  output logic [7:0]           fifo_data,
  output logic                 frame_done,
  output logic [LEN_WIDTH-1:0] frame_len,
  output logic [2:0]           frame_status,
  output logic [15:0]          good_cnt,
  output logic [15:0]          bad_cnt
);
  localparam logic [1:0] IDLE = 2'd0, PREAMBLE = 2'd1, DATA = 2'd2, DROP = 2'd3;
  localparam logic [3:0] PMIN = 4'(PREAMBLE_MIN);
  localparam logic [LEN_WIDTH-1:0] LMIN = LEN_WIDTH'(MIN_LEN);
  localparam logic [LEN_WIDTH-1:0] LMAX = LEN_WIDTH'(MAX_LEN + 1);
  logic [1:0] state;
  logic [3:0] pre_cnt;
  logic [LEN_WIDTH-1:0] byte_cnt, cnt_inc;
  logic [2:0] err, byte_err, done_status;
  logic report, done;
  assign cnt_inc = byte_cnt == LMAX ? byte_cnt : byte_cnt + 1'b1;
  assign byte_err = {fifo_full, rx_er, cnt_inc == LMAX};
  assign done_status = err | {2'b00, state == DATA && byte_cnt < LMIN};
  // only frames that reached DATA report status; DROP from IDLE/PREAMBLE/reset stays silent
  assign done = !rx_dv && (state == DATA || (state == DROP && report));
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= DROP;
      pre_cnt <= '0;
      byte_cnt <= '0;
      err <= '0;
      report <= 1'b0;
      fifo_wr_en <= 1'b0;
      fifo_data <= '0;
      frame_done <= 1'b0;
      frame_len <= '0;
      frame_status <= '0;
      good_cnt <= '0;
      bad_cnt <= '0;
    end else begin
      fifo_wr_en <= 1'b0;
      frame_done <= done;
      case (state)
        IDLE: if (rx_dv) begin
          pre_cnt <= 4'd1;
          report <= 1'b0;
          state <= rxd == 8'h55 ? PREAMBLE : DROP;
        end
        PREAMBLE: if (!rx_dv) state <= IDLE;
          else if (rxd == 8'h55) pre_cnt <= pre_cnt == 4'hF ? pre_cnt : pre_cnt + 4'd1;
          else if (rxd == 8'hD5 && pre_cnt >= PMIN) begin
            state <= DATA;
            byte_cnt <= '0;
            err <= '0;
          end else state <= DROP;
        DATA: if (!rx_dv) state <= IDLE;
          else begin
            byte_cnt <= cnt_inc;
            if (|byte_err) begin
              err <= byte_err;
              report <= 1'b1;
              state <= DROP;
            end else begin
              fifo_wr_en <= 1'b1;
              fifo_data <= rxd;
            end
          end
        default: if (!rx_dv) begin
            state <= IDLE;
            report <= 1'b0;
          end else byte_cnt <= cnt_inc;
      endcase
      if (done) begin
        frame_len <= byte_cnt;
        frame_status <= done_status;
        if (done_status == 3'b000) good_cnt <= good_cnt == 16'hFFFF ? good_cnt : good_cnt + 16'd1;
        else bad_cnt <= bad_cnt == 16'hFFFF ? bad_cnt : bad_cnt + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_eth_rx_framer.sv
// tb_eth_rx_framer: scoreboard bench; stimulus pushes expected FIFO bytes and frame reports, a monitor pops and compares.
module tb_eth_rx_framer;
  logic clk = 1'b0;
  logic rst, rx_dv, rx_er, fifo_full;
  logic [7:0] rxd;
  logic fifo_wr_en, frame_done;
  logic [7:0] fifo_data;
  logic [10:0] frame_len;
  logic [2:0] frame_status;
  logic [15:0] good_cnt, bad_cnt;
  typedef struct packed {
    logic [10:0] len;
    logic [2:0] st;
    logic [15:0] g;
    logic [15:0] b;
  } done_t;
  logic [7:0] exp_q[$];
  done_t done_q[$];
  int checks = 0, errors = 0;
  int exp_good = 0, exp_bad = 0;
  logic prev_done = 1'b0;

  eth_rx_framer dut (
    .clk(clk), .rst(rst), .rx_dv(rx_dv), .rx_er(rx_er), .rxd(rxd), .fifo_full(fifo_full),
    .fifo_wr_en(fifo_wr_en), .fifo_data(fifo_data), .frame_done(frame_done), .frame_len(frame_len),
    .frame_status(frame_status), .good_cnt(good_cnt), .bad_cnt(bad_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (fifo_wr_en) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected got=%h want=none", fifo_data);
      end else begin
        logic [7:0] b;
        b = exp_q.pop_front();
        if (fifo_data !== b) begin
          errors++;
          $display("FAIL wr_data got=%h want=%h", fifo_data, b);
        end
      end
    end
    if (frame_done) begin
      checks++;
      if (done_q.size() == 0) begin
        errors++;
        $display("FAIL done_unexpected got len=%0d st=%b", frame_len, frame_status);
      end else begin
        done_t d;
        d = done_q.pop_front();
        if ({frame_len, frame_status, good_cnt, bad_cnt} !== d) begin
          errors++;
          $display("FAIL done_report got len=%0d st=%b g=%0d b=%0d want len=%0d st=%b g=%0d b=%0d",
                   frame_len, frame_status, good_cnt, bad_cnt, d.len, d.st, d.g, d.b);
        end
      end
      if (prev_done) begin
        checks++;
        errors++;
        $display("FAIL done_width got=2cycles want=1cycle");
      end
    end
    prev_done <= frame_done;
  end

  task automatic frame(input int pre_n, input int n, input int full_at, input int er_at,
                       input int rst_at, input int idle);
    int e, lim;
    logic [2:0] st;
    done_t d;
    if (pre_n >= 7) begin
      e = 1519;
      if (full_at > 0 && full_at < e) e = full_at;
      if (er_at > 0 && er_at < e) e = er_at;
      lim = (rst_at > 0 && rst_at < e) ? rst_at : e;
      for (int i = 1; i <= n && i < lim; i++) exp_q.push_back(8'(i - 1));
      if (rst_at > 0 && rst_at <= n) begin
        exp_good = 0;
        exp_bad = 0;
      end else begin
        st = e <= n ? {full_at == e, er_at == e, e == 1519} : {2'b00, n < 64};
        if (st == 3'b000) exp_good++;
        else exp_bad++;
        d.len = 11'(n < 1519 ? n : 1519);
        d.st = st;
        d.g = 16'(exp_good);
        d.b = 16'(exp_bad);
        done_q.push_back(d);
      end
    end
    for (int p = 0; p < pre_n; p++) begin
      @(negedge clk);
      rx_dv = 1'b1; rxd = 8'h55;
    end
    @(negedge clk);
    rxd = 8'hD5;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      rxd = 8'(i - 1);
      fifo_full = i == full_at;
      rx_er = i == er_at;
      rst = i == rst_at;
    end
    @(negedge clk);
    {rx_dv, rx_er, fifo_full, rst, rxd} = '0;
    repeat (idle - 1) @(negedge clk);
  endtask

  initial begin
    {rx_dv, rx_er, fifo_full, rxd} = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({fifo_wr_en, fifo_data, frame_done, frame_len, frame_status, good_cnt, bad_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_state got wr=%b d=%h done=%b len=%0d st=%b g=%0d b=%0d want all zero",
               fifo_wr_en, fifo_data, frame_done, frame_len, frame_status, good_cnt, bad_cnt);
    end
    @(negedge clk);
    frame(7, 64, 0, 0, 0, 3);
    frame(7, 10, 0, 0, 0, 3);
    frame(7, 100, 50, 0, 0, 3);
    frame(7, 80, 0, 20, 0, 3);
    frame(7, 1600, 0, 0, 0, 3);
    frame(3, 20, 0, 0, 0, 1);
    frame(7, 64, 0, 0, 0, 3);
    frame(7, 70, 5, 5, 0, 3);
    frame(7, 60, 0, 0, 30, 1);
    frame(8, 70, 0, 0, 0, 1);
    frame(7, 65, 0, 0, 0, 1);
    frame(9, 1518, 0, 0, 0, 1);
    frame(7, 63, 0, 0, 0, 5);
    checks++;
    if (exp_q.size() != 0 || done_q.size() != 0) begin
      errors++;
      $display("FAIL drain got bytes_left=%0d frames_left=%0d want 0 0", exp_q.size(), done_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/eth_rx_framer.md
ETH_RX_FRAMER -- requirements
Module: eth_rx_framer

Interface
REQ-001 SHALL have parameter PREAMBLE_MIN, default 7, meaning the minimum count of 0x55 bytes required before SFD 0xD5.
REQ-002 SHALL have parameter MIN_LEN, default 64, meaning the minimum legal frame length in bytes after SFD.
REQ-003 SHALL have parameter MAX_LEN, default 1518, meaning the maximum legal frame length in bytes after SFD.
REQ-004 SHALL have parameter LEN_WIDTH, default 11, meaning the width of the length counter and frame_len; it SHALL hold MAX_LEN+1.
REQ-005 clk  input  1  sole clock; all logic on posedge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 rx_dv  input  1  byte-valid from PHY (GMII-style).
REQ-008 rx_er  input  1  PHY receive error, qualified by rx_dv.
REQ-009 rxd  input  8  receive byte.
REQ-010 fifo_full  input  1  full flag of downstream receive FIFO.
REQ-011 fifo_wr_en  output  1  write strobe to FIFO.
REQ-012 fifo_data  output  8  byte to FIFO.
REQ-013 frame_done  output  1  one-cycle end-of-frame status pulse.
REQ-014 frame_len  output  LEN_WIDTH  bytes received after SFD (saturating), valid with frame_done.
REQ-015 frame_status  output  3  {overflow, rx_error, length_err}, valid with frame_done; 3'b000 = good frame.
REQ-016 good_cnt  output  16  saturating count of frames with frame_status==0.
REQ-017 bad_cnt  output  16  saturating count of frames with frame_status!=0.

Function
REQ-018 SHALL implement states IDLE, PREAMBLE, DATA, DROP; all outputs registered.
REQ-019 IDLE: rx_dv=1 & rxd=0x55 -> PREAMBLE, pre_cnt=1; rx_dv=1 & any other byte -> DROP (no status); rx_dv=0 -> stay.
REQ-020 PREAMBLE: rxd=0x55 -> pre_cnt+1 (saturate at 15); rxd=0xD5 & pre_cnt>=PREAMBLE_MIN -> DATA, byte_cnt=0; any other byte or short preamble -> DROP (no status); rx_dv=0 -> IDLE (no status).
REQ-021 DATA, byte with rx_dv=1, rx_er=0, fifo_full=0: fifo_wr_en=1, fifo_data=rxd on the next cycle (latency 1), byte_cnt+1.
REQ-022 DATA, byte with fifo_full=1: byte not written, overflow latched, -> DROP.
REQ-023 DATA, byte with rx_er=1: byte not written, rx_error latched, -> DROP; rx_er and fifo_full together latch both bits.
REQ-024 DATA, byte_cnt reaching MAX_LEN+1: byte not written, length_err latched, -> DROP.
REQ-025 DATA, rx_dv=0: -> IDLE; next cycle frame_done=1, frame_len=byte_cnt, length_err=1 if byte_cnt<MIN_LEN.
REQ-026 DROP entered from DATA: byte_cnt keeps counting (saturate at MAX_LEN+1, not written); on rx_dv=0 -> IDLE and pulse frame_done with latched status.
REQ-027 DROP entered from IDLE/PREAMBLE/reset: on rx_dv=0 -> IDLE, no frame_done.
REQ-028 fifo_wr_en SHALL never assert while fifo_full was 1 in the sampling cycle; no lookahead on fifo_full.
REQ-029 frame_done SHALL be exactly one cycle; frame_len/frame_status SHALL hold until next frame_done.
REQ-030 good_cnt/bad_cnt increment in the frame_done cycle, saturate at 0xFFFF, never wrap.
REQ-031 Back-to-back frames with one idle cycle (rx_dv=0) SHALL be received without loss.

Reset
REQ-032 rst=1 SHALL set state=DROP (frame in progress ignored until rx_dv=0), fifo_wr_en=0, fifo_data=0, frame_done=0, frame_len=0, frame_status=0, good_cnt=0, bad_cnt=0, all internal counters 0.
REQ-033 rst asserted mid-frame SHALL suppress frame_done for that frame; no further FIFO writes from it.

Verification
REQ-034 7x0x55, 0xD5, 64 bytes 0x00..0x3F, rx_dv low -> 64 writes in order, frame_done, frame_len=64, status=000, good_cnt=1.
REQ-035 Same with 10 payload bytes -> 10 writes, frame_len=10, status=001, bad_cnt=1.
REQ-036 100-byte frame, fifo_full=1 on byte 50 -> 49 writes, frame_len=100, status=100.
REQ-037 rx_er=1 on byte 20 of 80-byte frame -> 19 writes, status=010; 1600-byte frame -> 1518 writes, frame_len=1519, status=001.
REQ-038 Preamble of 3x0x55 then 0xD5 -> no writes, no frame_done; following good frame after one idle cycle -> accepted.
REQ-039 rst pulsed at byte 30 with rx_dv held high -> no frame_done, no writes until rx_dv low; next frame good.
